// File: rtl/imuldiv_mul_mac_issuer.sv
// Dot-product initiator: streams operand pairs into a pipelined multiplier under a credit limit
// and accumulates the 64-bit products. Define IMULDIV_MAC_SATURATE_EN for a saturating accumulator.
module imuldiv_mul_mac_issuer #(
  parameter int MAX_INFLIGHT = 4,
  parameter int LEN_W        = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             cmd_val,
  output logic             cmd_rdy,
  input  logic [31:0]      opnd_a,
  input  logic [31:0]      opnd_b,
  input  logic             opnd_val,
  output logic             opnd_rdy,
  output logic [31:0]      mulreq_msg_a,
  output logic [31:0]      mulreq_msg_b,
  output logic             mulreq_val,
  input  logic             mulreq_rdy,
  input  logic [63:0]      mulresp_msg_result,
  input  logic             mulresp_val,
  output logic             mulresp_rdy,
  output logic [63:0]      acc_result,
  output logic             acc_val,
  input  logic             acc_rdy
);

  localparam int              IF_W   = $clog2(MAX_INFLIGHT + 1);
  localparam logic [IF_W-1:0] MAX_IF = IF_W'(MAX_INFLIGHT);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_RESULT} state_e;

  state_e            state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  issued_q, issued_d;
  logic [LEN_W-1:0]  retired_q, retired_d;
  logic [IF_W-1:0]   inflight_q, inflight_d;
  logic [63:0]       acc_q, acc_d, acc_sum;
  logic              issue_gate;
  logic              cmd_fire, req_fire, resp_fire, acc_fire;

  assign cmd_fire  = cmd_val && cmd_rdy;
  assign req_fire  = mulreq_val && mulreq_rdy;
  assign resp_fire = mulresp_val && mulresp_rdy;
  assign acc_fire  = acc_val && acc_rdy;

  assign mulreq_msg_a = opnd_a;
  assign mulreq_msg_b = opnd_b;
  assign acc_result   = acc_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (cmd_fire) state_d = (cmd_len == '0) ? S_RESULT : S_ISSUE;
      // The last issue may coincide with the final retire; both counters are already folded in.
      S_ISSUE:  if (req_fire && issued_d == len_q)
                  state_d = (retired_d == len_q) ? S_RESULT : S_DRAIN;
      S_DRAIN:  if (retired_d == len_q) state_d = S_RESULT;
      S_RESULT: if (acc_fire) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_rdy     = (state_q == S_IDLE);
    acc_val     = (state_q == S_RESULT);
    mulresp_rdy = (state_q == S_ISSUE) || (state_q == S_DRAIN);
    issue_gate  = (state_q == S_ISSUE) && (issued_q < len_q) && (inflight_q < MAX_IF);
    mulreq_val  = issue_gate && opnd_val;
    opnd_rdy    = issue_gate && mulreq_rdy;
  end

`ifdef IMULDIV_MAC_SATURATE_EN
  logic [64:0] sum_wide;
  always_comb begin
    sum_wide = {acc_q[63], acc_q} + {mulresp_msg_result[63], mulresp_msg_result};
    acc_sum  = sum_wide[63:0];
    // Sign bits disagree only on signed overflow; clamp toward the overflow direction.
    if (sum_wide[64] != sum_wide[63])
      acc_sum = sum_wide[64] ? 64'h8000_0000_0000_0000 : 64'h7fff_ffff_ffff_ffff;
  end
`else
  always_comb acc_sum = acc_q + mulresp_msg_result;
`endif

  always_comb begin
    len_d      = len_q;
    issued_d   = issued_q;
    retired_d  = retired_q;
    acc_d      = acc_q;
    inflight_d = inflight_q;
    if (cmd_fire) begin
      len_d     = cmd_len;
      issued_d  = '0;
      retired_d = '0;
      acc_d     = '0;
    end else begin
      if (req_fire) issued_d = issued_q + LEN_W'(1);
      if (resp_fire) begin
        retired_d = retired_q + LEN_W'(1);
        acc_d     = acc_sum;
      end
    end
    unique case ({req_fire, resp_fire})
      2'b10:   inflight_d = inflight_q + IF_W'(1);
      2'b01:   inflight_d = inflight_q - IF_W'(1);
      default: inflight_d = inflight_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      len_q      <= '0;
      issued_q   <= '0;
      retired_q  <= '0;
      inflight_q <= '0;
      acc_q      <= '0;
    end else begin
      len_q      <= len_d;
      issued_q   <= issued_d;
      retired_q  <= retired_d;
      inflight_q <= inflight_d;
      acc_q      <= acc_d;
    end
  end

`ifndef SYNTHESIS
  // A response with nothing outstanding means the multiplier broke the protocol.
  always_ff @(posedge clk) begin
    if (!reset && resp_fire) assert (inflight_q != '0);
  end
`endif

endmodule

// File: tb/tb_imuldiv_mul_mac_issuer.sv
// Directed bench for imuldiv_mul_mac_issuer: behavioural 4-cycle multiplier, operand feeder,
// result sink with optional stalls.
module tb_imuldiv_mul_mac_issuer;

  localparam int MAXIF = 2;
  localparam int LAT   = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  cmd_len = '0;
  logic        cmd_val = 1'b0;
  logic        cmd_rdy;
  logic [31:0] opnd_a = '0, opnd_b = '0;
  logic        opnd_val = 1'b0;
  logic        opnd_rdy;
  logic [31:0] mulreq_msg_a, mulreq_msg_b;
  logic        mulreq_val;
  logic        mulreq_rdy = 1'b0;
  logic [63:0] mulresp_msg_result = '0;
  logic        mulresp_val = 1'b0;
  logic        mulresp_rdy;
  logic [63:0] acc_result;
  logic        acc_val;
  logic        acc_rdy = 1'b0;

  imuldiv_mul_mac_issuer #(.MAX_INFLIGHT(MAXIF), .LEN_W(8)) dut (
    .clk(clk), .reset(reset),
    .cmd_len(cmd_len), .cmd_val(cmd_val), .cmd_rdy(cmd_rdy),
    .opnd_a(opnd_a), .opnd_b(opnd_b), .opnd_val(opnd_val), .opnd_rdy(opnd_rdy),
    .mulreq_msg_a(mulreq_msg_a), .mulreq_msg_b(mulreq_msg_b),
    .mulreq_val(mulreq_val), .mulreq_rdy(mulreq_rdy),
    .mulresp_msg_result(mulresp_msg_result), .mulresp_val(mulresp_val),
    .mulresp_rdy(mulresp_rdy),
    .acc_result(acc_result), .acc_val(acc_val), .acc_rdy(acc_rdy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Behavioural multiplier: fires are decided on stable values just after the falling edge.
  longint q_prod[$];
  int     q_due[$];
  int     cyc = 0;
  int     inflight_tb = 0;
  int     max_inflight = 0;
  int     resp_given = 0;
  int     resp_limit = 1000000;
  bit     req_seen = 1'b0;
  bit     rand_req = 1'b0;
  bit     rand_resp = 1'b0;

  always begin
    @(negedge clk);
    cyc++;
    mulreq_rdy = rand_req ? ($urandom_range(0, 3) != 0) : 1'b1;
    if (q_prod.size() > 0 && q_due[0] <= cyc && resp_given < resp_limit &&
        !(rand_resp && $urandom_range(0, 2) == 0)) begin
      mulresp_val        = 1'b1;
      mulresp_msg_result = q_prod[0];
    end else begin
      mulresp_val        = 1'b0;
      mulresp_msg_result = '0;
    end
    #1;
    if (reset) begin
      q_prod.delete();
      q_due.delete();
      inflight_tb = 0;
    end else begin
      if (mulreq_val) req_seen = 1'b1;
      if (mulresp_val && mulresp_rdy) begin
        void'(q_prod.pop_front());
        void'(q_due.pop_front());
        inflight_tb--;
        resp_given++;
      end
      if (mulreq_val && mulreq_rdy) begin
        q_prod.push_back(longint'($signed(mulreq_msg_a)) * longint'($signed(mulreq_msg_b)));
        q_due.push_back(cyc + LAT);
        inflight_tb++;
      end
      if (inflight_tb > max_inflight) max_inflight = inflight_tb;
    end
  end

  logic [31:0] va[16];
  logic [31:0] vb[16];
  int          sink_wait;

  task automatic send_cmd(input string tag, input int len);
    int t = 0;
    @(negedge clk);
    cmd_len = 8'(len);
    cmd_val = 1'b1;
    #1;
    while (!cmd_rdy && t < 50) begin @(negedge clk); #1; t++; end
    if (t >= 50) check({tag, "_cmd_timeout"}, cmd_rdy, 1);
    @(negedge clk);
    cmd_val = 1'b0;
  endtask

  task automatic feed(input string tag, input int len);
    for (int i = 0; i < len; i++) begin
      int t = 0;
      opnd_a   = va[i];
      opnd_b   = vb[i];
      opnd_val = 1'b1;
      #1;
      while (!opnd_rdy && t < 200) begin @(negedge clk); #1; t++; end
      if (t >= 200) check({tag, "_opnd_timeout"}, opnd_rdy, 1);
      @(negedge clk);
    end
    opnd_val = 1'b0;
  endtask

  task automatic sink(input string tag, input logic [63:0] exp, input bit stall);
    int t = 0;
    acc_rdy = 1'b0;
    #1;
    while (!acc_val && t < 500) begin @(negedge clk); #1; t++; end
    sink_wait = t;
    check({tag, "_acc_val"}, acc_val, 1);
    if (stall) begin
      repeat (2) begin
        @(negedge clk); #1;
        check({tag, "_hold"}, acc_result, exp);
      end
    end
    acc_rdy = 1'b1;
    check({tag, "_result"}, acc_result, exp);
    @(negedge clk);
    acc_rdy = 1'b0;
    #1;
    check({tag, "_back_idle"}, cmd_rdy, 1);
  endtask

  task automatic run_dot(input string tag, input int len, input logic [63:0] exp,
                         input bit stall);
    send_cmd(tag, len);
    fork
      feed(tag, len);
      sink(tag, exp, stall);
    join
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cmd_rdy"}, cmd_rdy, 1);
    check({tag, "_opnd_rdy"}, opnd_rdy, 0);
    check({tag, "_mulreq_val"}, mulreq_val, 0);
    check({tag, "_mulresp_rdy"}, mulresp_rdy, 0);
    check({tag, "_acc_val"}, acc_val, 0);
    check({tag, "_acc_result"}, acc_result, 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs("rst");
    @(negedge clk);
    reset = 1'b0;

    // 3*5
    va[0] = 32'd3; vb[0] = 32'd5;
    run_dot("len1", 1, 64'h0000_0000_0000_000f, 1'b0);

    // 1 - 1 + 24 + 64 = 88
    va[0] = 32'd1;        vb[0] = 32'd1;
    va[1] = 32'hffffffff; vb[1] = 32'd1;
    va[2] = 32'd8;        vb[2] = 32'd3;
    va[3] = 32'hfffffff8; vb[3] = 32'hfffffff8;
    run_dot("len4", 4, 64'h0000_0000_0000_0058, 1'b0);

    req_seen = 1'b0;
    run_dot("len0", 0, 64'h0, 1'b0);
    check("len0_no_mulreq", 64'(req_seen), 0);
    check("len0_latency", 64'(sink_wait), 0);

    // Latency 4 against 2 credits: the credit limit must be reached but never exceeded.
    for (int i = 0; i < 8; i++) begin va[i] = 32'd2; vb[i] = 32'd2; end
    max_inflight = 0;
    run_dot("credit", 8, 64'h0000_0000_0000_0020, 1'b0);
    check("credit_max_inflight", 64'(max_inflight), 64'(MAXIF));

    // 10 * (2^31-1)^2 = 10 * 0x3fffffff00000001, wrapped to 64 bits.
    for (int i = 0; i < 10; i++) begin va[i] = 32'h7fffffff; vb[i] = 32'h7fffffff; end
    rand_req = 1'b1;
    rand_resp = 1'b1;
    run_dot("stall", 10, 64'h7fff_fff6_0000_000a, 1'b1);
    rand_req = 1'b0;
    rand_resp = 1'b0;
    check("stall_max_inflight_bound", 64'(max_inflight <= MAXIF), 1);

    // Retire one of two products, hold the other so the block sits in DRAIN with acc=25.
    va[0] = 32'd5; vb[0] = 32'd5;
    va[1] = 32'd5; vb[1] = 32'd5;
    resp_limit = resp_given + 1;
    send_cmd("drain", 2);
    feed("drain", 2);
    repeat (8) @(negedge clk);
    #1;
    check("drain_cmd_rdy", cmd_rdy, 0);
    check("drain_mulresp_rdy", mulresp_rdy, 1);
    check("drain_opnd_rdy", opnd_rdy, 0);
    check("drain_partial_acc", acc_result, 64'd25);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_reset_outputs("midrst");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    resp_limit = 1000000;

    va[0] = 32'd2; vb[0] = 32'd3;
    run_dot("after_rst", 1, 64'h0000_0000_0000_0006, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
